alu_arbiter: RTL

//  Shares the single datapath ALU between two requesters (req0: pipeline execute, req1: aux/debug port).

---
 rtl/alu_arbiter_if.sv | 48 ++++
 rtl/alu_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle of signals between the two ALU requesters, the arbiter, and the shared
// combinational ALU. The master side is the requesters plus the ALU itself. The
// slave side is the arbiter.
interface alu_arbiter_if #(
    parameter int DSIZE = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [DSIZE-1:0] req0_a;
    logic [DSIZE-1:0] req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [DSIZE-1:0] req1_a;
    logic [DSIZE-1:0] req1_b;
    logic [2:0]       req1_op;

    logic             resp0_valid;
    logic             resp1_valid;
    logic [DSIZE-1:0] resp_data;
    logic             resp_zero;

    logic [DSIZE-1:0] alu_a;
    logic [DSIZE-1:0] alu_b;
    logic [DSIZE-1:0] alu_imm;
    logic [2:0]       alu_op;
    logic [DSIZE-1:0] alu_result;
    logic             alu_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_result, alu_zero,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_zero,
        input  alu_a, alu_b, alu_imm, alu_op
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_result, alu_zero,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_zero,
        output alu_a, alu_b, alu_imm, alu_op
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing the single combinational ALU between the execute
// pipeline (requester 0) and the aux/debug port (requester 1).
// Sequence: IDLE (grant + latch operands) -> EXEC (hold ALU inputs for 1 cycle,
// or MUL_CYCLES for a multiply) -> RESP (one-cycle response pulse) -> IDLE.
// The multiply opcode is 3'd7. The other opcodes pass through to the ALU untouched.
module alu_arbiter #(
    parameter int DSIZE      = 16,
    parameter int MUL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic [2:0] OP_MUL   = 3'd7;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q;
    logic             last_grant_q;   // last winner, which is also the owner of the op in flight
    logic [DSIZE-1:0] alu_a_q;
    logic [DSIZE-1:0] alu_b_q;
    logic [2:0]       alu_op_q;
    logic [DSIZE-1:0] resp_data_q;
    logic             resp_zero_q;

    logic             grant_valid;
    logic             grant_sel;
    logic             handshake;
    logic [2:0]       sel_op;

    // Pick the winner in IDLE. On a tie the winner is the requester that did not win last time.
    always_comb begin
        grant_valid = 1'b0;
        grant_sel   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b0;
            end else if (bus.req1_valid) begin
                grant_valid = 1'b1;
                grant_sel   = 1'b1;
            end
        end
    end

    // Any grant in IDLE is a handshake because ready follows the grant combinationally.
    assign handshake = grant_valid & ~rst;
    assign sel_op    = grant_sel ? bus.req1_op : bus.req0_op;

    // Next-state logic for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = EXEC;
            EXEC:    if (cnt_q == 4'd0) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state: FSM register, EXEC countdown, and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                last_grant_q <= grant_sel;
                cnt_q        <= (sel_op == OP_MUL) ? MUL_LOAD : 4'd0;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Latch the winner's operands at the handshake. They hold steady through EXEC and after it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= 3'd0;
        end else if (handshake) begin
            alu_a_q  <= grant_sel ? bus.req1_a : bus.req0_a;
            alu_b_q  <= grant_sel ? bus.req1_b : bus.req0_b;
            alu_op_q <= sel_op;
        end
    end

    // Capture the ALU outputs on the last EXEC cycle. They hold until the next capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_zero_q <= 1'b0;
        end else if (state_q == EXEC && cnt_q == 4'd0) begin
            resp_data_q <= bus.alu_result;
            resp_zero_q <= bus.alu_zero;
        end
    end

    assign bus.req0_ready  = handshake & ~grant_sel;
    assign bus.req1_ready  = handshake &  grant_sel;
    assign bus.resp0_valid = (state_q == RESP) & ~last_grant_q;
    assign bus.resp1_valid = (state_q == RESP) &  last_grant_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.resp_zero   = resp_zero_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_imm     = alu_b_q;
    assign bus.alu_op      = alu_op_q;
endmodule
